// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// Byte-strobed partial writes are turned into a read followed by a merged write.
module sram_arbiter #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 18
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     p0_req_valid,
   output logic                     p0_req_ready,
   input  logic                     p0_req_we,
   input  logic [ADDRWIDTH-1:0]     p0_req_addr,
   input  logic [DATAWIDTH-1:0]     p0_req_wdata,
   input  logic [DATAWIDTH/8-1:0]   p0_req_wstrb,
   output logic                     p0_rsp_valid,
   output logic [DATAWIDTH-1:0]     p0_rsp_rdata,
   input  logic                     p1_req_valid,
   output logic                     p1_req_ready,
   input  logic                     p1_req_we,
   input  logic [ADDRWIDTH-1:0]     p1_req_addr,
   input  logic [DATAWIDTH-1:0]     p1_req_wdata,
   input  logic [DATAWIDTH/8-1:0]   p1_req_wstrb,
   output logic                     p1_rsp_valid,
   output logic [DATAWIDTH-1:0]     p1_rsp_rdata,
   output logic                     sram_CEN,
   output logic                     sram_WEN,
   output logic [ADDRWIDTH-1:0]     sram_A,
   output logic [DATAWIDTH-1:0]     sram_D,
   input  logic [DATAWIDTH-1:0]     sram_Q
);

   localparam int NB = DATAWIDTH / 8;

   typedef enum logic {ST_IDLE, ST_RMW} state_t;

   state_t                r_state;
   logic                  r_last;        // port granted most recently; 1 favours port 0
   logic                  r_pend_valid;
   logic                  r_pend_port;
   logic                  r_pend_read;
   logic                  r_rmw_port;
   logic [ADDRWIDTH-1:0]  r_rmw_addr;
   logic [DATAWIDTH-1:0]  r_rmw_wdata;
   logic [NB-1:0]         r_rmw_wstrb;

   logic                  w_idle;
   logic                  w_grant0;
   logic                  w_grant1;
   logic                  w_accept;
   logic                  w_sel;
   logic                  w_we;
   logic                  w_full;
   logic                  w_rsp;
   logic [ADDRWIDTH-1:0]  w_addr;
   logic [DATAWIDTH-1:0]  w_wdata;
   logic [NB-1:0]         w_wstrb;
   logic [DATAWIDTH-1:0]  w_merged;

   assign w_idle       = (r_state == ST_IDLE) && !RST;
   assign w_grant0     = p0_req_valid && (!p1_req_valid || r_last);
   assign w_grant1     = p1_req_valid && (!p0_req_valid || !r_last);
   assign p0_req_ready = w_idle && w_grant0;
   assign p1_req_ready = w_idle && w_grant1;
   assign w_accept     = p0_req_ready || p1_req_ready;
   assign w_sel        = p1_req_ready;

   assign w_we    = w_sel ? p1_req_we    : p0_req_we;
   assign w_addr  = w_sel ? p1_req_addr  : p0_req_addr;
   assign w_wdata = w_sel ? p1_req_wdata : p0_req_wdata;
   assign w_wstrb = w_sel ? p1_req_wstrb : p0_req_wstrb;
   assign w_full  = &w_wstrb;

   // Q still holds the word read in the accept cycle while in RMW
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_merge
         assign w_merged[gi*8 +: 8] = r_rmw_wstrb[gi] ? r_rmw_wdata[gi*8 +: 8] : sram_Q[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      sram_CEN = 1'b1;
      sram_WEN = 1'b1;
      sram_A   = '0;
      sram_D   = '0;
      if (!RST) begin
         if (r_state == ST_RMW) begin
            sram_CEN = 1'b0;
            sram_WEN = 1'b0;
            sram_A   = r_rmw_addr;
            sram_D   = w_merged;
         end else if (w_accept) begin
            sram_CEN = 1'b0;
            sram_A   = w_addr;
            if (w_we && w_full) begin
               sram_WEN = 1'b0;
               sram_D   = w_wdata;
            end
         end
      end
   end

   assign w_rsp        = r_pend_valid && !RST;
   assign p0_rsp_valid = w_rsp && !r_pend_port;
   assign p1_rsp_valid = w_rsp && r_pend_port;
   assign p0_rsp_rdata = (p0_rsp_valid && r_pend_read) ? sram_Q : '0;
   assign p1_rsp_rdata = (p1_rsp_valid && r_pend_read) ? sram_Q : '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= ST_IDLE;
         r_last       <= 1'b1;
         r_pend_valid <= 1'b0;
         r_pend_port  <= 1'b0;
         r_pend_read  <= 1'b0;
         r_rmw_port   <= 1'b0;
         r_rmw_addr   <= '0;
         r_rmw_wdata  <= '0;
         r_rmw_wstrb  <= '0;
      end else begin
         r_pend_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_last <= w_sel;
                  if (w_we && !w_full) begin
                     r_rmw_port  <= w_sel;
                     r_rmw_addr  <= w_addr;
                     r_rmw_wdata <= w_wdata;
                     r_rmw_wstrb <= w_wstrb;
                     r_state     <= ST_RMW;
                  end else begin
                     r_pend_valid <= 1'b1;
                     r_pend_port  <= w_sel;
                     r_pend_read  <= !w_we;
                  end
               end
            end
            ST_RMW: begin
               r_pend_valid <= 1'b1;
               r_pend_port  <= r_rmw_port;
               r_pend_read  <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_sram_arbiter;

   localparam int DW = 32;
   localparam int AW = 18;
   localparam int NB = DW / 8;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           p0_req_valid = 1'b0, p0_req_we = 1'b0;
   logic [AW-1:0]  p0_req_addr = '0;
   logic [DW-1:0]  p0_req_wdata = '0;
   logic [NB-1:0]  p0_req_wstrb = '0;
   logic           p1_req_valid = 1'b0, p1_req_we = 1'b0;
   logic [AW-1:0]  p1_req_addr = '0;
   logic [DW-1:0]  p1_req_wdata = '0;
   logic [NB-1:0]  p1_req_wstrb = '0;
   logic           p0_req_ready, p0_rsp_valid, p1_req_ready, p1_rsp_valid;
   logic [DW-1:0]  p0_rsp_rdata, p1_rsp_rdata;
   logic           sram_CEN, sram_WEN;
   logic [AW-1:0]  sram_A;
   logic [DW-1:0]  sram_D;
   logic [DW-1:0]  sram_Q;
   logic [DW-1:0]  sram_mem [0:1023];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   sram_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
      .CLK(CLK), .RST(RST),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
      .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A), .sram_D(sram_D),
      .sram_Q(sram_Q)
   );

   // Single-port SRAM: registered read data, Q zero on any non-read cycle
   initial begin
      sram_Q <= '0;
      for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
      forever begin
         @(posedge CLK);
         if (!sram_CEN && !sram_WEN) begin
            sram_mem[sram_A[9:0]] = sram_D;
            sram_Q <= '0;
         end else if (!sram_CEN) begin
            sram_Q <= sram_mem[sram_A[9:0]];
         end else begin
            sram_Q <= '0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
   endtask

   function automatic logic ready_of(input int p);
      return (p != 0) ? p1_req_ready : p0_req_ready;
   endfunction
   function automatic logic valid_of(input int p);
      return (p != 0) ? p1_req_valid : p0_req_valid;
   endfunction
   function automatic logic rspv_of(input int p);
      return (p != 0) ? p1_rsp_valid : p0_rsp_valid;
   endfunction
   function automatic logic [DW-1:0] rspd_of(input int p);
      return (p != 0) ? p1_rsp_rdata : p0_rsp_rdata;
   endfunction

   task automatic set_port(input int p, input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [NB-1:0] s);
      if (p == 0) begin
         p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d; p0_req_wstrb = s;
      end else begin
         p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d; p1_req_wstrb = s;
      end
   endtask

   // Reference model: transaction-level view of arbitration, memory and responses
   typedef struct {
      int            due;
      logic          port;
      logic [DW-1:0] data;
   } rsp_t;

   initial begin : model
      logic [DW-1:0] ref_mem [0:1023];
      rsp_t          exp_q[$];
      rsp_t          e;
      int            cyc;
      logic          m_last, in_rmw, rmw_port, g, we, chk_d;
      logic [AW-1:0] rmw_addr, a, exp_a;
      logic [DW-1:0] rmw_val, d, old, exp_d, ed0, ed1;
      logic [NB-1:0] s;
      logic          exp_cen, exp_wen, er0, er1, gr0, gr1;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      cyc = 0; m_last = 1'b1; in_rmw = 1'b0; rmw_port = 1'b0; rmw_addr = '0; rmw_val = '0;
      forever begin
         @(negedge CLK);
         cyc++;
         exp_cen = 1'b1; exp_wen = 1'b1; exp_a = '0; exp_d = '0; chk_d = 1'b0;
         er0 = 1'b0; er1 = 1'b0; ed0 = '0; ed1 = '0; gr0 = 1'b0; gr1 = 1'b0;
         if (RST) begin
            in_rmw = 1'b0; m_last = 1'b1; exp_q.delete();
         end else begin
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               e = exp_q.pop_front();
               if (e.due == cyc) begin
                  if (e.port) begin er1 = 1'b1; ed1 = e.data; end
                  else begin er0 = 1'b1; ed0 = e.data; end
               end
            end
            if (in_rmw) begin
               exp_cen = 1'b0; exp_wen = 1'b0; exp_a = rmw_addr; exp_d = rmw_val; chk_d = 1'b1;
               ref_mem[rmw_addr[9:0]] = rmw_val;
               exp_q.push_back('{due: cyc + 1, port: rmw_port, data: '0});
               in_rmw = 1'b0;
            end else if (p0_req_valid || p1_req_valid) begin
               g = (p0_req_valid && p1_req_valid) ? !m_last : p1_req_valid;
               m_last = g; gr0 = !g; gr1 = g;
               we = g ? p1_req_we    : p0_req_we;
               a  = g ? p1_req_addr  : p0_req_addr;
               d  = g ? p1_req_wdata : p0_req_wdata;
               s  = g ? p1_req_wstrb : p0_req_wstrb;
               exp_cen = 1'b0; exp_a = a;
               old = ref_mem[a[9:0]];
               if (!we) begin
                  exp_q.push_back('{due: cyc + 1, port: g, data: old});
               end else if (s == {NB{1'b1}}) begin
                  exp_wen = 1'b0; exp_d = d; chk_d = 1'b1;
                  ref_mem[a[9:0]] = d;
                  exp_q.push_back('{due: cyc + 1, port: g, data: '0});
               end else begin
                  for (int b = 0; b < NB; b++)
                     rmw_val[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
                  rmw_addr = a; rmw_port = g; in_rmw = 1'b1;
               end
            end
         end
         chk("p0_ready", p0_req_ready, gr0);
         chk("p1_ready", p1_req_ready, gr1);
         chk("p0_rsp_valid", p0_rsp_valid, er0);
         chk("p1_rsp_valid", p1_rsp_valid, er1);
         chk("p0_rsp_rdata", p0_rsp_rdata, ed0);
         chk("p1_rsp_rdata", p1_rsp_rdata, ed1);
         chk("sram_CEN", sram_CEN, exp_cen);
         chk("sram_WEN", sram_WEN, exp_wen);
         chk("sram_A", sram_A, exp_a);
         if (chk_d) chk("sram_D", sram_D, exp_d);
         if (p0_rsp_valid) $display("rsp port0 cyc=%0d rdata=%h", cyc, p0_rsp_rdata);
         if (p1_rsp_valid) $display("rsp port1 cyc=%0d rdata=%h", cyc, p1_rsp_rdata);
      end
   end

   // One request: wait (bounded) for acceptance, then for its response
   task automatic req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] s, output logic [DW-1:0] rd, output int lat);
      logic got;
      got = 1'b0; rd = '0; lat = 0;
      set_port(p, 1'b1, we, a, d, s);
      for (int k = 0; k < 50; k++) begin
         @(negedge CLK);
         if (ready_of(p)) begin got = 1'b1; break; end
      end
      chk("accept_seen", got, 1'b1);
      @(posedge CLK); #1;
      set_port(p, 1'b0, 1'b0, '0, '0, '0);
      if (!got) return;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         lat++;
         if (rspv_of(p)) begin rd = rspd_of(p); got = 1'b1; break; end
      end
      chk("rsp_seen", got, 1'b1);
      @(posedge CLK); #1;
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   task automatic rand_driver(input int p, input int ncyc);
      logic acc;
      acc = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         if (!valid_of(p) || acc) begin
            if ($urandom_range(0, 9) < 7)
               set_port(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 1) != 0) ? {NB{1'b1}} : NB'($urandom_range(0, 15)));
            else
               set_port(p, 1'b0, 1'b0, '0, '0, '0);
         end
         @(negedge CLK);
         acc = valid_of(p) && ready_of(p);
         @(posedge CLK); #1;
      end
      set_port(p, 1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [DW-1:0] rd;
      int            lat;
      int            order [4];
      logic          got;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      // full write then read-back
      req(0, 1'b1, 'h10, 32'hDEADBEEF, 4'hF, rd, lat);
      chk("wr_rdata_zero", rd, 32'h0);
      chk("wr_latency", lat, 1);
      req(0, 1'b0, 'h10, '0, '0, rd, lat);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_latency", lat, 1);

      // contention after reset alternates starting with port 0
      req(1, 1'b1, 'h1, 32'h1111_0001, 4'hF, rd, lat);
      req(1, 1'b1, 'h2, 32'h2222_0002, 4'hF, rd, lat);
      pulse_reset();
      set_port(0, 1'b1, 1'b0, 'h1, '0, '0);
      set_port(1, 1'b1, 1'b0, 'h2, '0, '0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         order[i] = p1_req_ready ? 1 : (p0_req_ready ? 0 : 2);
         @(posedge CLK); #1;
      end
      set_port(0, 1'b0, 1'b0, '0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 4; i++) chk("alt_grant", order[i], i % 2);
      @(posedge CLK); #1;

      // partial write through RMW
      req(1, 1'b1, 'h20, 32'h11223344, 4'hF, rd, lat);
      req(1, 1'b1, 'h20, 32'hAABBCCDD, 4'b0101, rd, lat);
      chk("rmw_latency", lat, 2);
      chk("rmw_rdata_zero", rd, 32'h0);
      req(0, 1'b0, 'h20, '0, '0, rd, lat);
      chk("rmw_readback", rd, 32'h11BB33DD);

      // back-to-back reads, no bubbles
      for (int i = 0; i < 8; i++) req(0, 1'b1, AW'(i), 32'h100 + i, 4'hF, rd, lat);
      for (int i = 0; i < 8; i++) begin
         set_port(0, 1'b1, 1'b0, AW'(i), '0, '0);
         @(negedge CLK);
         chk("b2b_ready", p0_req_ready, 1'b1);
         if (i > 0) begin
            chk("b2b_rsp_valid", p0_rsp_valid, 1'b1);
            chk("b2b_rsp_data", p0_rsp_rdata, 32'h100 + i - 1);
         end
         @(posedge CLK); #1;
      end
      set_port(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge CLK);
      chk("b2b_last_valid", p0_rsp_valid, 1'b1);
      chk("b2b_last_data", p0_rsp_rdata, 32'h107);
      @(posedge CLK); #1;

      // reset lands on the RMW write cycle
      req(0, 1'b1, 'h30, 32'h55667788, 4'hF, rd, lat);
      set_port(0, 1'b1, 1'b1, 'h30, 32'h0, 4'b0011);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (p0_req_ready) begin got = 1'b1; break; end
      end
      chk("rst_rmw_accept", got, 1'b1);
      @(posedge CLK); #1;
      set_port(0, 1'b0, 1'b0, '0, '0, '0);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_rmw_cen", sram_CEN, 1'b1);
      chk("rst_rmw_rsp", p0_rsp_valid, 1'b0);
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("rst_no_rsp", p0_rsp_valid, 1'b0);
         @(posedge CLK); #1;
      end
      req(0, 1'b0, 'h30, '0, '0, rd, lat);
      chk("rst_loc_unchanged", rd, 32'h55667788);
      chk("rst_next_latency", lat, 1);

      // all-zero strobe still goes through RMW and leaves memory alone
      req(1, 1'b1, 'h30, 32'hFFFFFFFF, 4'b0000, rd, lat);
      chk("zero_strb_latency", lat, 2);
      req(1, 1'b0, 'h30, '0, '0, rd, lat);
      chk("zero_strb_unchanged", rd, 32'h55667788);

      // random traffic on both ports with one reset in the middle
      fork
         rand_driver(0, 1500);
         rand_driver(1, 1500);
         begin
            repeat (700) @(posedge CLK);
            #1 RST = 1'b1;
            @(posedge CLK);
            #1 RST = 1'b0;
         end
      join
      repeat (4) @(posedge CLK);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
